// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO slice.
//
// Provides a ceil(log2) width helper, the pointer-width rule (one extra
// wrap bit above the RAM address), default parameter values and the packed
// status-flag record registered by the FIFO top level.
package fifo_pkg;

  localparam int DEFAULT_DATA_WIDTH         = 16;
  localparam int DEFAULT_ADDR_WIDTH         = 4;
  localparam int DEFAULT_ALMOST_FULL_MARGIN = 2;
  localparam int DEFAULT_ALMOST_EMPTY_LEVEL = 2;

  // Number of bits needed to represent the values 0..value-1.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result++;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

  // Read/write pointers carry one wrap bit above the RAM address so that
  // full and empty can be told apart when the address bits match.
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  localparam int DEFAULT_PTR_WIDTH = DEFAULT_ADDR_WIDTH + 1;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_status_t;

  localparam fifo_status_t STATUS_RESET = '{
    full:         1'b0,
    empty:        1'b1,
    almost_full:  1'b0,
    almost_empty: 1'b1
  };

endpackage

// File: rtl/ram_simple_dual_port.sv
// Simple dual-port RAM: one write port, one registered read port.
//
// Ports:
//   clk      - clock, all activity on posedge
//   rst_n    - asynchronous active-low reset of the read data register only
//   wr_en    - write enable; wr_data is stored at wr_addr
//   wr_addr  - write address
//   wr_data  - write data
//   rd_en    - read enable; mem[rd_addr] is loaded into rd_data
//   rd_addr  - read address
//   rd_data  - registered read data, holds its value while rd_en = 0
//
// The storage array itself has no reset. A read and a write to the same
// address in one cycle return the old contents.
module ram_simple_dual_port #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_d;
  logic [DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      rd_data_d = mem[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/sync_fifo_ram.sv
// Parametrised single-clock FIFO built on a simple dual-port RAM.
//
// Ports:
//   Clock        - single clock, posedge
//   Reset        - asynchronous active-low reset
//   iPush/iData  - write request and its data
//   iPop         - read request; oData/oDataValid follow one cycle later
//   iClearErrors - synchronous clear of the sticky error flags
//   oData        - read data, holds when oDataValid = 0
//   oDataValid   - one-cycle pulse after each accepted pop
//   oCount       - occupancy 0..DEPTH
//   oFull/oEmpty/oAlmostFull/oAlmostEmpty - registered status flags
//   oOverflow/oUnderflow - sticky error flags
//
// The top level only holds pointers, occupancy, flags and error state;
// storage lives in ram_simple_dual_port. Every output is a flop.
module sync_fifo_ram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH         = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH         = DEFAULT_ADDR_WIDTH,
  parameter int ALMOST_FULL_LEVEL  = (1 << ADDR_WIDTH) - DEFAULT_ALMOST_FULL_MARGIN,
  parameter int ALMOST_EMPTY_LEVEL = DEFAULT_ALMOST_EMPTY_LEVEL
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iPush,
  input  logic [DATA_WIDTH-1:0] iData,
  input  logic                  iPop,
  input  logic                  iClearErrors,
  output logic [DATA_WIDTH-1:0] oData,
  output logic                  oDataValid,
  output logic [ADDR_WIDTH:0]   oCount,
  output logic                  oFull,
  output logic                  oEmpty,
  output logic                  oAlmostFull,
  output logic                  oAlmostEmpty,
  output logic                  oOverflow,
  output logic                  oUnderflow
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PTR_W = ptr_width(ADDR_WIDTH);
  localparam int CNT_W = clog2(DEPTH + 1);

  logic [PTR_W-1:0] wr_ptr_d, wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_d, rd_ptr_q;
  logic [CNT_W-1:0] count_d, count_q;
  fifo_status_t     status_d, status_q;
  logic             overflow_d, overflow_q;
  logic             underflow_d, underflow_q;
  logic             valid_d, valid_q;
  logic             push_ok;
  logic             pop_ok;

  // A pop frees a slot in the same cycle, so a push on a full FIFO is still
  // taken when it is paired with an accepted pop. On an empty FIFO the pop
  // is refused but the push still lands; the new word is readable next cycle.
  always_comb begin
    pop_ok      = iPop & ~status_q.empty;
    push_ok     = iPush & (~status_q.full | pop_ok);

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    count_d     = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);

    // Flags come from the next count so they line up with oCount.
    status_d              = STATUS_RESET;
    status_d.full         = (count_d == CNT_W'(DEPTH));
    status_d.empty        = (count_d == '0);
    status_d.almost_full  = (count_d >= CNT_W'(ALMOST_FULL_LEVEL));
    status_d.almost_empty = (count_d <= CNT_W'(ALMOST_EMPTY_LEVEL));

    // Error events take priority over a clear in the same cycle.
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (iPush && !push_ok) begin
      overflow_d = 1'b1;
    end else if (iClearErrors) begin
      overflow_d = 1'b0;
    end
    if (iPop && !pop_ok) begin
      underflow_d = 1'b1;
    end else if (iClearErrors) begin
      underflow_d = 1'b0;
    end

    valid_d     = pop_ok;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      status_q    <= STATUS_RESET;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      status_q    <= status_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      valid_q     <= valid_d;
    end
  end

  ram_simple_dual_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (Clock),
    .rst_n   (Reset),
    .wr_en   (push_ok),
    .wr_addr (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wr_data (iData),
    .rd_en   (pop_ok),
    .rd_addr (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rd_data (oData)
  );

  assign oDataValid   = valid_q;
  assign oCount       = count_q;
  assign oFull        = status_q.full;
  assign oEmpty       = status_q.empty;
  assign oAlmostFull  = status_q.almost_full;
  assign oAlmostEmpty = status_q.almost_empty;
  assign oOverflow    = overflow_q;
  assign oUnderflow   = underflow_q;

endmodule

// File: tb/tb_sync_fifo_ram.sv
// Self-checking bench for sync_fifo_ram (16 x 16-bit configuration).
// Expected behaviour comes from a queue-based model of the FIFO rules.
module tb_sync_fifo_ram;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          iPush;
  logic [DW-1:0] iData;
  logic          iPop;
  logic          iClearErrors;
  logic [DW-1:0] oData;
  logic          oDataValid;
  logic [AW:0]   oCount;
  logic          oFull, oEmpty, oAlmostFull, oAlmostEmpty;
  logic          oOverflow, oUnderflow;

  int compared   = 0;
  int mismatched = 0;

  logic [DW-1:0] modelQ[$];
  logic [DW-1:0] expData;
  bit            expValid;
  bit            expOvf;
  bit            expUdf;

  sync_fifo_ram #(
    .DATA_WIDTH         (DW),
    .ADDR_WIDTH         (AW),
    .ALMOST_FULL_LEVEL  (AF),
    .ALMOST_EMPTY_LEVEL (AE)
  ) dut (
    .Clock        (clock),
    .Reset        (reset),
    .iPush        (iPush),
    .iData        (iData),
    .iPop         (iPop),
    .iClearErrors (iClearErrors),
    .oData        (oData),
    .oDataValid   (oDataValid),
    .oCount       (oCount),
    .oFull        (oFull),
    .oEmpty       (oEmpty),
    .oAlmostFull  (oAlmostFull),
    .oAlmostEmpty (oAlmostEmpty),
    .oOverflow    (oOverflow),
    .oUnderflow   (oUnderflow)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Compare every output against the model's view of the FIFO.
  task automatic checkAll(input string step);
    int size;
    size = modelQ.size();
    checkOutput({step, " count"},       32'(oCount),       32'(size));
    checkOutput({step, " full"},        32'(oFull),        32'(size == DEPTH));
    checkOutput({step, " empty"},       32'(oEmpty),       32'(size == 0));
    checkOutput({step, " almostFull"},  32'(oAlmostFull),  32'(size >= AF));
    checkOutput({step, " almostEmpty"}, 32'(oAlmostEmpty), 32'(size <= AE));
    checkOutput({step, " overflow"},    32'(oOverflow),    32'(expOvf));
    checkOutput({step, " underflow"},   32'(oUnderflow),   32'(expUdf));
    checkOutput({step, " dataValid"},   32'(oDataValid),   32'(expValid));
    checkOutput({step, " data"},        32'(oData),        32'(expData));
  endtask

  task automatic modelReset();
    modelQ.delete();
    expData  = '0;
    expValid = 1'b0;
    expOvf   = 1'b0;
    expUdf   = 1'b0;
  endtask

  // Drive one cycle of requests, advance the model by the FIFO rules and
  // check all outputs shortly after the clock edge.
  task automatic applyStimulus(input string step, input logic doPush,
                               input logic [DW-1:0] word, input logic doPop,
                               input logic doClr);
    int size;
    bit popAcc;
    bit pushAcc;
    iPush        = doPush;
    iData        = word;
    iPop         = doPop;
    iClearErrors = doClr;
    size    = modelQ.size();
    popAcc  = doPop && (size > 0);
    pushAcc = doPush && ((size < DEPTH) || popAcc);
    @(posedge clock);
    #1;
    if (popAcc) expData = modelQ.pop_front();
    if (pushAcc) modelQ.push_back(word);
    expValid = popAcc;
    if (doPush && !pushAcc) expOvf = 1'b1;
    else if (doClr)         expOvf = 1'b0;
    if (doPop && (size == 0)) expUdf = 1'b1;
    else if (doClr)           expUdf = 1'b0;
    iPush        = 1'b0;
    iPop         = 1'b0;
    iClearErrors = 1'b0;
    checkAll(step);
  endtask

  initial begin
    reset        = 1'b0;
    iPush        = 1'b0;
    iData        = '0;
    iPop         = 1'b0;
    iClearErrors = 1'b0;
    modelReset();
    repeat (2) @(posedge clock);
    #1;
    checkAll("reset");
    reset = 1'b1;

    // Reset mid-operation with a pop in flight.
    for (int i = 0; i < 3; i++) applyStimulus("preReset", 1'b1, 16'hA000 + 16'(i), 1'b0, 1'b0);
    iPop = 1'b1;
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    iPop = 1'b0;
    modelReset();
    checkAll("asyncReset");
    @(posedge clock);
    #1;
    checkAll("heldReset");
    reset = 1'b1;

    // Fill, overflow, drain.
    for (int i = 1; i <= DEPTH; i++) applyStimulus("fill", 1'b1, 16'(i), 1'b0, 1'b0);
    applyStimulus("overflowPush", 1'b1, 16'h00FF, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) applyStimulus("drain", 1'b0, '0, 1'b1, 1'b0);
    applyStimulus("clearOvf", 1'b0, '0, 1'b0, 1'b1);

    // Full-rate streaming with one word resident, wrapping the pointers.
    applyStimulus("wrapPrime", 1'b1, 16'h1000, 1'b0, 1'b0);
    for (int i = 1; i <= 40; i++) applyStimulus("wrap", 1'b1, 16'h1000 + 16'(i), 1'b1, 1'b0);
    applyStimulus("wrapDrain", 1'b0, '0, 1'b1, 1'b0);

    // Simultaneous push and pop while full.
    for (int i = 0; i < DEPTH; i++) applyStimulus("refill", 1'b1, 16'h2000 + 16'(i), 1'b0, 1'b0);
    applyStimulus("fullBoth", 1'b1, 16'h2ABC, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH; i++) applyStimulus("redrain", 1'b0, '0, 1'b1, 1'b0);

    // Simultaneous push and pop while empty.
    applyStimulus("emptyBoth", 1'b1, 16'h3333, 1'b1, 1'b0);
    applyStimulus("emptyBothRead", 1'b0, '0, 1'b1, 1'b0);

    // Error set beats clear, then a clean clear.
    applyStimulus("clearClash", 1'b0, '0, 1'b1, 1'b1);
    applyStimulus("clearClean", 1'b0, '0, 1'b0, 1'b1);

    // Randomised traffic in fill-biased, drain-biased and balanced phases.
    for (int i = 0; i < 300; i++) begin
      int pushPct;
      pushPct = (i < 100) ? 70 : ((i < 200) ? 30 : 50);
      applyStimulus("random",
                    1'($urandom_range(99) < 32'(pushPct)),
                    16'($urandom),
                    1'($urandom_range(99) < 32'(100 - pushPct)),
                    1'($urandom_range(99) < 5));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sync_fifo_ram.md
# sync_fifo_ram

- Parametrised synchronous FIFO: a simple dual-port block RAM with separate read and write pointer counters, occupancy tracking and status flags.
- Successor to the team's fixed single-read-port RAM and free-running up-counter. Adds configurable width and depth, full/empty protection, programmable almost-full/almost-empty thresholds and sticky overflow/underflow error flags.
- Sits between producer and consumer datapaths that share one clock domain.

## Interface
- DATA_WIDTH, 16, width of each stored word.
- ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH (must be ≥ 2).
- ALMOST_FULL_LEVEL, DEPTH-2, oAlmostFull asserts when count ≥ this value.
- ALMOST_EMPTY_LEVEL, 2, oAlmostEmpty asserts when count ≤ this value.

Ports:
- Clock  in  1  single clock, all logic on posedge.
- Reset  in  1  asynchronous, active-low reset (asserted when 0); release is synchronised externally.
- iPush  in  1  write request.
- iData  in  DATA_WIDTH  write data, sampled with iPush.
- iPop  in  1  read request.
- iClearErrors  in  1  synchronous clear of sticky error flags.
- oData  out  DATA_WIDTH  read data, valid when oDataValid = 1.
- oDataValid  out  1  one-cycle pulse, asserted the cycle after an accepted pop.
- oCount  out  ADDR_WIDTH+1  current occupancy, range 0..DEPTH.
- oFull, oEmpty, oAlmostFull, oAlmostEmpty  out  1 each  status flags.
- oOverflow, oUnderflow  out  1 each  sticky error flags.

## Operation
- **Reset (Reset = 0, asynchronous):**
  - Write/read pointers = 0, oCount = 0, oEmpty = 1, oAlmostEmpty = 1.
  - oFull = oAlmostFull = oOverflow = oUnderflow = oDataValid = 0, oData = 0.
  - RAM contents are not cleared.
  - Reset mid-operation discards all stored words immediately. A pop in flight does not produce oDataValid after reset.
- **Pointers:** ADDR_WIDTH+1 bits wide. The low ADDR_WIDTH bits address the RAM; the MSB is a wrap bit.
  - Empty when the pointers are equal.
  - Full when the low bits are equal and the MSBs differ.
  - Pointers wrap naturally modulo 2*DEPTH.
- **Push accepted** when iPush = 1 and (oFull = 0, or an accepted pop occurs in the same cycle). Writes iData at the write pointer, then increments it.
- **Pop accepted** when iPop = 1 and oEmpty = 0. Reads at the read pointer, then increments it. oData/oDataValid appear on the next cycle.
- **Push rejected** (full with no accepted pop): data dropped, oOverflow set.
- **Pop rejected** (empty): oUnderflow set, oDataValid stays 0.
  - A simultaneous push is still accepted. There is no bypass: the word becomes readable from the next cycle.
- **Count update:** oCount += accepted push − accepted pop. Push+pop both accepted leaves count unchanged.
- **Flags:** all status flags are registered and derived from the next count, so they are valid in the same cycle as oCount.
- **Sticky errors:** cleared by iClearErrors = 1. If an error event and iClearErrors occur in the same cycle, the set wins.
- **oData:** holds its last value when oDataValid = 0.

## Timing
- Push-to-readable latency: 1 cycle. A word pushed at edge N can be popped at edge N+1.
- Pop-to-data latency: 1 cycle. Pop at edge N gives oData/oDataValid after edge N+1.
- Full-rate streaming: one push and one pop per cycle, sustained indefinitely, including at full and empty.
- No combinational path from inputs to outputs.

## Structure
- Shared package `fifo_pkg`:
  - clog2-style width helper.
  - Pointer width constant (ADDR_WIDTH+1).
  - Default threshold localparams.
- One sub-module, `ram_simple_dual_port`:
  - One write port, one registered read port, no reset on the array.
  - Same write/read-enable semantics as the existing single-read-port RAM, with depth exactly 2**ADDR_WIDTH.
- Top level holds pointers, count, flags and error logic only.

## Test plan
- **Reset:** push 3 words, assert Reset = 0 mid-cycle → all outputs return to reset values immediately; oCount = 0, oEmpty = 1.
- **Fill, drain, overflow:** DEPTH = 16; push 0x0001..0x0010 → oFull = 1 and oAlmostFull = 1 at count 14. A 17th push sets oOverflow and leaves count at 16. Pop 16 words → data 0x0001..0x0010 in order, each one cycle after its pop.
- **Wrap-around:** push/pop 40 words at full rate through a 16-deep FIFO → data in order, oCount stays 1 throughout, no error flags.
- **Simultaneous at boundaries:**
  - Push+pop when full → both accepted, count stays 16, no overflow.
  - Push+pop when empty → push accepted, oUnderflow = 1, count becomes 1.
- **Error clear precedence:** pop on empty with iClearErrors = 1 in the same cycle → oUnderflow = 1. The next cycle with iClearErrors = 1 and no error → oUnderflow = 0.
